// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch initiator for a single-cycle instruction memory port.
// Holds the PC and issues sequential word fetches. A stalled response is
// replayed. A redirect flushes the buffer and restarts fetch. A nonzero
// memory exception code or a misaligned redirect target halts issue until
// the next aligned redirect. Responses are buffered in a small FIFO that
// feeds decode over a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   redirect/_pc         flush and restart fetch at redirect_pc
//   im_en, im_addr       memory request strobe (combinational) and address (= pc)
//   im_addrout, im_dout  response address tag and instruction word (one cycle later)
//   im_stall             response not valid this cycle; replay the request
//   im_exception         nonzero = fetch fault for the response address
//   out_valid/out_ready  decode handshake on the FIFO head
//   out_pc/inst/exc      head entry (all zero while the FIFO is empty)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_addrout,
  input  logic [31:0] im_dout,
  input  logic        im_stall,
  input  logic [2:0]  im_exception,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [2:0]  out_exc
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);
  localparam logic [2:0]    EXC_MISALIGNED = 3'b100;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_inst_q [FIFO_DEPTH];
  logic [2:0]  fifo_exc_q  [FIFO_DEPTH];

  logic          pop;
  logic          accept;
  logic          misaligned;
  logic          push;
  logic [AW-1:0] push_idx;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;
  logic [2:0]    push_exc;
  logic [OW-1:0] occupancy;

  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
  assign out_inst   = out_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign out_exc    = out_valid ? fifo_exc_q[rd_ptr_q]  : 3'b000;

  assign pop        = out_valid && out_ready;
  assign accept     = inflight_q && !im_stall && !redirect;
  assign misaligned = (redirect_pc[1:0] != 2'b00);

  // Entries held after this edge, counting the in-flight slot as reserved.
  // This guarantees every issued request has room when it returns.
  assign occupancy  = OW'(count_q) + OW'(inflight_q) - OW'(pop);

  assign im_addr = pc_q;
  assign im_en   = !rst && !redirect && !halted_q && !(inflight_q && im_stall)
                   && (occupancy < DEPTH_W);

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = im_en;
    halted_d   = halted_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    push       = 1'b0;
    push_idx   = wr_ptr_q;
    push_pc    = im_addrout;
    push_inst  = im_dout;
    push_exc   = im_exception;

    if (redirect) begin
      // Flush wins over pop and any arriving response. A misaligned target
      // becomes the sole entry in slot 0 of the emptied buffer.
      pc_d      = redirect_pc;
      halted_d  = misaligned;
      push      = misaligned;
      push_idx  = '0;
      push_pc   = redirect_pc;
      push_inst = 32'h0;
      push_exc  = EXC_MISALIGNED;
      rd_ptr_d  = '0;
      wr_ptr_d  = misaligned ? AW'(1) : '0;
      count_d   = misaligned ? CW'(1) : '0;
    end else begin
      if (inflight_q && im_stall) begin
        pc_d = req_pc_q;          // replay next cycle; im_en is low now
      end else if (im_en) begin
        pc_d = pc_q + 32'd4;
      end
      if (im_en) begin
        req_pc_d = pc_q;
      end
      if (accept) begin
        push     = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (im_exception != 3'b000) begin
          halted_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fifo_pc_q[gi]   <= 32'h0;
          fifo_inst_q[gi] <= 32'h0;
          fifo_exc_q[gi]  <= 3'b000;
        end else if (push && (push_idx == AW'(gi))) begin
          fifo_pc_q[gi]   <= push_pc;
          fifo_inst_q[gi] <= push_inst;
          fifo_exc_q[gi]  <= push_exc;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit. A one-cycle instruction memory model returns
// 32'h1000 + word index for every address; a one-shot stall at address 8 and
// a fault code at address 0x10 can be enabled per step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_addrout;
  logic [31:0] im_dout;
  logic        im_stall;
  logic [2:0]  im_exception;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  out_exc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_en       (im_en),
    .im_addr     (im_addr),
    .im_addrout  (im_addrout),
    .im_dout     (im_dout),
    .im_stall    (im_stall),
    .im_exception(im_exception),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_exc     (out_exc)
  );

  // Memory model: response one cycle after an accepted request.
  logic        rsp_valid  = 1'b0;
  logic [31:0] rsp_addr   = 32'h0;
  logic        stall_en   = 1'b0;
  logic        stall_done = 1'b0;
  logic        exc_en     = 1'b0;

  always @(posedge clk) begin
    rsp_valid <= im_en;
    rsp_addr  <= im_addr;
    if (!stall_en) stall_done <= 1'b0;
    else if (im_stall) stall_done <= 1'b1;
  end

  assign im_addrout   = rsp_addr;
  assign im_dout      = 32'h1000 + {2'b00, rsp_addr[31:2]};
  assign im_stall     = rsp_valid && stall_en && !stall_done && (rsp_addr == 32'h8);
  assign im_exception = (rsp_valid && exc_en && (rsp_addr == 32'h10)) ? 3'b001 : 3'b000;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && !redirect)
      $display("pop pc=%h inst=%h exc=%0d", out_pc, out_inst, out_exc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [2:0] exc);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_pc"},    out_pc, pc);
    chk({tag, "_inst"},  out_inst, inst);
    chk({tag, "_exc"},   {29'b0, out_exc}, {29'b0, exc});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    sample();
    chk("rst_im_en", {31'b0, im_en}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc",    out_pc, 32'h0);
    chk("rst_inst",  out_inst, 32'h0);
    chk("rst_exc",   {29'b0, out_exc}, 32'd0);

    // Streaming with out_ready held high.
    adv(); rst = 1'b0;
    sample();
    chk("c0_im_en",  {31'b0, im_en}, 32'd1);
    chk("c0_addr",   im_addr, 32'h0);
    chk("c0_valid",  {31'b0, out_valid}, 32'd0);
    adv(); sample();
    chk("c1_valid",  {31'b0, out_valid}, 32'd0);
    chk("c1_addr",   im_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      adv(); sample();
      chk_head("stream", 32'(4 * k), 32'h1000 + 32'(k), 3'b000);
    end

    // Backpressure: head 12 held, in-flight 16 lands, issue stops.
    out_ready = 1'b0; #1;
    chk("bp_im_en0", {31'b0, im_en}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      adv(); sample();
      chk_head("bp_hold", 32'hC, 32'h1003, 3'b000);
      chk("bp_im_en", {31'b0, im_en}, 32'd0);
    end
    out_ready = 1'b1; #1;
    chk("bp_rel_en",   {31'b0, im_en}, 32'd1);
    chk("bp_rel_addr", im_addr, 32'h14);
    for (int k = 4; k < 7; k++) begin
      adv(); sample();
      chk_head("bp_resume", 32'(4 * k), 32'h1000 + 32'(k), 3'b000);
    end

    // Reset mid-stream clears outputs immediately.
    rst = 1'b1; #1;
    chk("mrst_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_im_en", {31'b0, im_en}, 32'd0);
    chk("mrst_pc",    out_pc, 32'h0);
    stall_en = 1'b1;
    adv(); adv(); rst = 1'b0;
    sample();
    chk("st_c0_addr", im_addr, 32'h0);
    adv(); adv(); sample();
    chk_head("st_h0", 32'h0, 32'h1000, 3'b000);
    adv(); sample();
    chk_head("st_h4", 32'h4, 32'h1001, 3'b000);
    chk("st_stall_en", {31'b0, im_en}, 32'd0);
    adv(); sample();
    chk("st_gap_valid", {31'b0, out_valid}, 32'd0);
    chk("st_replay_en", {31'b0, im_en}, 32'd1);
    chk("st_replay_addr", im_addr, 32'h8);
    adv(); sample();
    chk("st_gap2_valid", {31'b0, out_valid}, 32'd0);
    chk("st_next_addr", im_addr, 32'hC);
    adv(); sample();
    chk_head("st_h8", 32'h8, 32'h1002, 3'b000);
    adv(); sample();
    chk_head("st_h12", 32'hC, 32'h1003, 3'b000);

    // Aligned redirect while a head entry is buffered and a response arrives.
    redirect = 1'b1; redirect_pc = 32'h40; #1;
    chk("rd_im_en", {31'b0, im_en}, 32'd0);
    adv(); redirect = 1'b0;
    sample();
    chk("rd_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("rd_flush_pc",    out_pc, 32'h0);
    chk("rd_addr",        im_addr, 32'h40);
    chk("rd_en",          {31'b0, im_en}, 32'd1);
    adv(); sample();
    chk("rd_gap_valid", {31'b0, out_valid}, 32'd0);
    adv(); sample();
    chk_head("rd_h40", 32'h40, 32'h1010, 3'b000);
    adv(); sample();
    chk_head("rd_h44", 32'h44, 32'h1011, 3'b000);

    // Misaligned redirect: single fault entry, then issue stays off.
    redirect = 1'b1; redirect_pc = 32'h42; #1;
    adv(); redirect = 1'b0;
    sample();
    chk_head("mis_entry", 32'h42, 32'h0, 3'b100);
    chk("mis_im_en0", {31'b0, im_en}, 32'd0);
    adv(); sample();
    chk("mis_empty",  {31'b0, out_valid}, 32'd0);
    chk("mis_im_en1", {31'b0, im_en}, 32'd0);
    adv(); sample();
    chk("mis_im_en2", {31'b0, im_en}, 32'd0);

    // Aligned redirect to 0 resumes; fault reported at 0x10 halts issue.
    exc_en = 1'b1; redirect = 1'b1; redirect_pc = 32'h0; #1;
    chk("ex_rd_en", {31'b0, im_en}, 32'd0);
    adv(); redirect = 1'b0;
    sample();
    chk("ex_resume_en",   {31'b0, im_en}, 32'd1);
    chk("ex_resume_addr", im_addr, 32'h0);
    adv();
    for (int k = 0; k < 4; k++) begin
      adv(); sample();
      chk_head("ex_drain", 32'(4 * k), 32'h1000 + 32'(k), 3'b000);
    end
    adv(); sample();
    chk_head("ex_fault", 32'h10, 32'h1004, 3'b001);
    chk("ex_halt_en0", {31'b0, im_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      adv(); sample();
      chk("ex_halt_en", {31'b0, im_en}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
